// File: rtl/proc_ctrl_pkg.sv
// Shared op codes, state encodings and defaults for the processor run/load controller.
package proc_ctrl_pkg;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_RUN  = 2'd1,
        OP_STEP = 2'd2,
        OP_HALT = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;
endpackage

// File: rtl/proc_run_ctrl_if.sv
// Host-side command channel and program-byte stream of the run/load controller.
interface proc_run_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [7:0]        cmd_len;
    logic              cmd_ready;
    logic              cmd_err;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_len, ld_valid, ld_data,
        input  cmd_ready, cmd_err, ld_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, ld_valid, ld_data,
        output cmd_ready, cmd_err, ld_ready
    );
endinterface

// File: rtl/imem_load_seq.sv
// Streams a counted burst of program bytes into instruction memory, one write per byte.
module imem_load_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              done,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata
);
    logic [8:0]        rem;
    logic [ADDR_W-1:0] waddr;
    logic              busy;
    logic              acc;

    assign ld_ready = busy;
    assign acc      = ld_valid & busy;
    assign done     = acc & (rem == 9'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy       <= 1'b0;
            rem        <= '0;
            waddr      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= acc;
            if (start) begin
                busy  <= 1'b1;
                // len 0 encodes a full 256-byte image
                rem   <= {(len == 8'd0), len};
                waddr <= '0;
            end else if (acc) begin
                rem        <= rem - 9'd1;
                waddr      <= waddr + 1'b1;
                imem_addr  <= waddr;
                imem_wdata <= ld_data;
                if (rem == 9'd1) busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/proc_run_ctrl.sv
// Run/load sequencer: loads the program image, then gates the core's reset and clock enable.
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    proc_run_ctrl_if.slave    host,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              brk_en,
    input  logic [ADDR_W-1:0] brk_pc,
    output logic              cpu_reset_n,
    output logic              cpu_ce,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  cycle_cnt
);
    state_e     state, state_nx;
    op_e        op;
    logic [8:0] step_rem;
    logic       skip_bp, bp_hit, cmd_acc;
    logic       ld_start, ld_done, step_start, skip_nx;
    logic       rst_n_nx, cmd_err_q, cmd_err_nx;

    assign op             = op_e'(host.cmd_op);
    assign host.cmd_ready = (state != ST_LOAD);
    assign host.cmd_err   = cmd_err_q;
    assign cmd_acc        = host.cmd_valid & host.cmd_ready;
    assign bp_hit         = (state == ST_RUN) & brk_en & (cpu_pc == brk_pc) & ~skip_bp;
    assign cpu_ce         = ((state == ST_RUN) & ~bp_hit) | (state == ST_STEP);
    assign state_o        = state;

    always_comb begin
        state_nx   = state;
        ld_start   = 1'b0;
        step_start = 1'b0;
        skip_nx    = 1'b0;
        rst_n_nx   = cpu_reset_n;
        cmd_err_nx = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (cmd_acc) begin
                    case (op)
                        OP_LOAD: begin state_nx = ST_LOAD; ld_start = 1'b1; rst_n_nx = 1'b0; end
                        OP_RUN:  begin
                            state_nx = ST_RUN;
                            rst_n_nx = 1'b1;
                            // resuming from a breakpoint must execute the halted PC once
                            skip_nx  = (state == ST_HALTED);
                        end
                        OP_STEP: begin state_nx = ST_STEP; step_start = 1'b1; rst_n_nx = 1'b1; end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: if (ld_done) state_nx = ST_IDLE;
            ST_RUN: begin
                if (bp_hit) state_nx = ST_HALTED;
                if (cmd_acc) begin
                    case (op)
                        OP_HALT:          state_nx   = ST_HALTED;
                        OP_LOAD, OP_STEP: cmd_err_nx = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                if (step_rem == 9'd1) state_nx = ST_HALTED;
                if (cmd_acc) begin
                    case (op)
                        OP_HALT:         state_nx   = ST_HALTED;
                        OP_LOAD, OP_RUN: cmd_err_nx = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cpu_reset_n <= 1'b0;
            cmd_err_q   <= 1'b0;
            skip_bp     <= 1'b0;
            step_rem    <= '0;
            cycle_cnt   <= '0;
        end else begin
            state       <= state_nx;
            cpu_reset_n <= rst_n_nx;
            cmd_err_q   <= cmd_err_nx;
            skip_bp     <= skip_nx;
            if (step_start)             step_rem <= {(host.cmd_len == 8'd0), host.cmd_len};
            else if (state == ST_STEP)  step_rem <= step_rem - 9'd1;
            if (ld_start)                      cycle_cnt <= '0;
            else if (cpu_ce && !(&cycle_cnt))  cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    imem_load_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ld (
        .clk        (clk),
        .reset      (reset),
        .start      (ld_start),
        .len        (host.cmd_len),
        .ld_valid   (host.ld_valid),
        .ld_data    (host.ld_data),
        .ld_ready   (host.ld_ready),
        .done       (ld_done),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata)
    );
endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Run/load sequencer for the 8-bit 3-stage pipelined processor (IF/ID, ID/EX, EX/WB).
- Streams a program image into instruction memory while the core is held in reset.
- Then releases the core and gates its clock-enable for free-run, N-cycle single-step, host halt or PC breakpoint.
- Sits between the host/debug interface and the processor's reset/enable pins; counts executed cycles.

Parameters:
- ADDR_W, 8, instruction-memory address width (matches 8-bit PC)
- DATA_W, 8, instruction width
- CNT_W, 16, executed-cycle counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_op  in  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT
- cmd_len  in  8  LOAD: byte count; STEP: cycle count; 0 encodes 256
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_err  out  1  one-cycle pulse: command accepted but illegal in current state
- ld_valid  in  1  program byte valid
- ld_data  in  DATA_W  program byte
- ld_ready  out  1  byte accepted when ld_valid & ld_ready
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_pc  in  ADDR_W  processor fetch PC
- brk_en  in  1  breakpoint enable
- brk_pc  in  ADDR_W  breakpoint address
- cpu_reset_n  out  1  synchronous active-low reset to processor
- cpu_ce  out  1  processor clock enable (all pipeline registers and PC)
- state_o  out  3  current state encoding
- cycle_cnt  out  CNT_W  cycles with cpu_ce=1

Behaviour:
- Reset (reset=0 at clk edge):
  - state IDLE; cpu_reset_n=0, cpu_ce=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cmd_ready=1, ld_ready=0, cmd_err=0, cycle_cnt=0.
  - Reset mid-LOAD or mid-RUN aborts immediately with no further imem writes.
- States: IDLE(0), LOAD(1), RUN(2), STEP(3), HALTED(4).
- cmd_ready: 1 in IDLE, RUN, STEP, HALTED; 0 in LOAD.
- IDLE:
  - core held in reset.
  - LOAD -> LOAD, remaining=cmd_len, write address=0, cycle_cnt=0.
  - RUN -> RUN; STEP -> STEP.
  - HALT -> no-op.
- LOAD:
  - cpu_reset_n=0, cpu_ce=0, ld_ready=1.
  - Each accepted byte produces imem_we=1 the next cycle, with imem_addr = current write address and imem_wdata = byte. Latency 1, one write per byte, back-to-back at full rate.
  - Address increments after each write and wraps 255->0.
  - After the final byte is accepted: ld_ready=0 immediately; last write issues next cycle; state -> IDLE.
- Leaving IDLE for RUN/STEP: cpu_reset_n registered to 1 on acceptance, so the core leaves reset on the first RUN/STEP cycle with cpu_ce=1.
- RUN:
  - cpu_ce = ~bp_hit, combinational.
  - bp_hit = brk_en & (cpu_pc==brk_pc) & ~skip_bp.
  - On bp_hit: next state HALTED; the core freezes with PC==brk_pc unexecuted.
  - HALT -> HALTED, cpu_ce=0 from the next cycle.
  - LOAD or STEP -> cmd_err pulse, ignored.
- STEP:
  - cpu_ce=1 for exactly cmd_len cycles (256 if 0), then HALTED.
  - Breakpoints are ignored.
  - HALT aborts: cpu_ce=0 from the next cycle.
  - LOAD or RUN -> cmd_err pulse, ignored.
- HALTED:
  - cpu_ce=0; cpu_reset_n stays 1, preserving pipeline state.
  - RUN/STEP resume; skip_bp=1 for the first RUN cycle only, so a resume from a breakpoint advances.
  - LOAD -> cpu_reset_n=0, enters LOAD.
  - HALT -> no-op.
- cycle_cnt: +1 every cycle cpu_ce=1; saturates at all-ones; cleared only by reset or LOAD acceptance.
- Simultaneous bp_hit and HALT command in RUN: -> HALTED, cpu_ce=0 that cycle, no cmd_err.

Decomposition:
- Package proc_ctrl_pkg holds:
  - op codes OP_LOAD/OP_RUN/OP_STEP/OP_HALT
  - state encodings ST_IDLE..ST_HALTED
  - CNT_W default
- Sub-module imem_load_seq owns:
  - byte-count down-counter
  - address counter with wrap
  - registered write strobe
  - interface: start, len, ld handshake, done, imem_* outputs

Test Plan:
- Reset, LOAD len=3, bytes 0x41,0x82,0xC5 back-to-back -> imem_we on 3 consecutive cycles at addr 0,1,2 with those data; state IDLE after; cpu_reset_n=0 throughout.
- LOAD len=0, 256 bytes with random ld_valid gaps -> 256 writes, addr 0..255; no extra write; ld_ready drops after byte 256.
- After load: RUN, then HALT after 10 cycles -> cpu_reset_n rises on RUN acceptance; cpu_ce high 10 cycles; cycle_cnt=10; state HALTED.
- brk_en=1, brk_pc=0x05, RUN from reset -> cpu_ce drops the cycle cpu_pc==0x05; HALTED; a following RUN advances past 0x05 without re-halting.
- HALTED, STEP len=4 -> exactly 4 cpu_ce cycles, then HALTED; LOAD issued during STEP -> cmd_err pulse, no imem_we.
- reset=0 in the middle of a LOAD of 8 bytes after 4 bytes -> no further imem_we; all outputs at reset values the next cycle.
